note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/audio_pkg.sv | 52 +++++
 rtl/melody_rom.sv | 22 ++
 rtl/note_sequencer.sv | 151 +++++++++++++++
 tb/tb_note_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared note codes, melody entry layout and sequencer state type
// Contents:
//   NOTE_C4..NOTE_E5 : pitched note codes 0..9
//   NOTE_REST        : silent code 15
//   melody_entry_t   : {note[3:0], dur[7:0]}, dur in ticks, dur == 0 ends the melody
//   seq_state_t      : IDLE / PLAY / GAP / DONE
//   pitched()        : entry produces an audible note
//   default_melody() : short scale used when no table is supplied
package audio_pkg;

  localparam logic [3:0] NOTE_C4   = 4'd0;
  localparam logic [3:0] NOTE_D4   = 4'd1;
  localparam logic [3:0] NOTE_E4   = 4'd2;
  localparam logic [3:0] NOTE_F4   = 4'd3;
  localparam logic [3:0] NOTE_G4   = 4'd4;
  localparam logic [3:0] NOTE_A4   = 4'd5;
  localparam logic [3:0] NOTE_B4   = 4'd6;
  localparam logic [3:0] NOTE_C5   = 4'd7;
  localparam logic [3:0] NOTE_D5   = 4'd8;
  localparam logic [3:0] NOTE_E5   = 4'd9;
  localparam logic [3:0] NOTE_REST = 4'd15;

  typedef struct packed {
    logic [3:0] note;
    logic [7:0] dur;
  } melody_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } seq_state_t;

  // Codes 10..14 are carried through but never sound; a zero-length entry never sounds.
  function automatic logic pitched(input melody_entry_t e);
    return (e.note <= NOTE_E5) && (e.dur != 8'd0);
  endfunction

  function automatic logic [255:0][11:0] default_melody();
    logic [255:0][11:0] m;
    logic [3:0] n [16];
    m = '0;
    n = '{NOTE_C4, NOTE_D4, NOTE_E4, NOTE_F4, NOTE_G4, NOTE_A4, NOTE_B4, NOTE_C5,
          NOTE_D5, NOTE_E5, NOTE_D5, NOTE_C5, NOTE_B4, NOTE_A4, NOTE_G4, NOTE_REST};
    for (int i = 0; i < 16; i++) begin
      m[i] = {n[i], (i == 15) ? 8'd4 : 8'd2};
    end
    return m;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - combinational melody table, MELODY_LEN x 12 bits
// Ports:
//   addr  : entry address; addresses at or beyond MELODY_LEN read as zero (end marker)
//   entry : {note, dur} stored at addr
module melody_rom
  import audio_pkg::*;
#(
  parameter int                    MELODY_LEN = 16,
  parameter logic [255:0][11:0]    MELODY     = default_melody()
) (
  input  logic [7:0]    addr,
  output melody_entry_t entry
);

  always_comb begin
    entry = '0;
    if (int'(addr) < MELODY_LEN) begin
      entry = melody_entry_t'(MELODY[addr]);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - plays a melody table as timed notes separated by silent gaps
// Ports:
//   clk, reset       : system clock, asynchronous active-high reset
//   start, stop      : one-cycle playback requests (stop has priority)
//   note, note_valid : current note code (15 = rest) and pitched flag
//   busy, done       : not idle / one-cycle normal-completion pulse
//   index            : table entry currently playing
// Build option: NOTE_SEQUENCER_LOOP_EN restarts from entry 0 instead of finishing.
module note_sequencer
  import audio_pkg::*;
#(
  parameter int                 CLK_HZ     = 50_000_000,
  parameter int                 TICK_HZ    = 1000,
  parameter int                 GAP_TICKS  = 20,
  parameter int                 MELODY_LEN = 16,
  parameter logic [255:0][11:0] MELODY     = default_melody()
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] note,
  output logic       note_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] index
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);

  seq_state_t    state;
  logic [PRE_W-1:0] pre;
  logic [7:0]    cnt;
  logic [7:0]    cur_dur;
  logic [7:0]    rom_addr;
  melody_entry_t nxt;

  // The table is read one entry ahead: entry 0 while idle, index+1 while playing,
  // so the next note and its end-of-melody status are ready at the advance edge.
  assign rom_addr = (state == ST_IDLE) ? 8'd0 : index + 8'd1;

  melody_rom #(.MELODY_LEN(MELODY_LEN), .MELODY(MELODY)) u_rom (
    .addr  (rom_addr),
    .entry (nxt)
  );

`ifdef NOTE_SEQUENCER_LOOP_EN
  melody_entry_t first;
  melody_rom #(.MELODY_LEN(MELODY_LEN), .MELODY(MELODY)) u_rom_first (
    .addr  (8'd0),
    .entry (first)
  );
`endif

  logic tick, play_end, gap_end, to_gap, entry_done, finish, at_last;

  assign tick     = (pre == PRE_W'(TICK_DIV - 1));
  // A zero-length entry can only be entry 0; it occupies one PLAY cycle and ends the melody.
  assign play_end = (state == ST_PLAY) &&
                    ((cur_dur == 8'd0) || (tick && (cnt == cur_dur - 8'd1)));
  assign gap_end  = (state == ST_GAP) && tick && (cnt == 8'(GAP_TICKS - 1));
  assign to_gap   = play_end && (cur_dur != 8'd0) && (GAP_TICKS > 0);
  assign entry_done = (play_end && !to_gap) || gap_end;
  assign at_last  = (index == 8'(MELODY_LEN - 1)) || (nxt.dur == 8'd0);
  assign finish   = (cur_dur == 8'd0) || at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      note       <= NOTE_REST;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      index      <= 8'd0;
      pre        <= '0;
      cnt        <= 8'd0;
      cur_dur    <= 8'd0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= ST_IDLE;
        note       <= NOTE_REST;
        note_valid <= 1'b0;
        busy       <= 1'b0;
        index      <= 8'd0;
        pre        <= '0;
        cnt        <= 8'd0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_PLAY;
              busy       <= 1'b1;
              index      <= 8'd0;
              note       <= nxt.note;
              note_valid <= pitched(nxt);
              cur_dur    <= nxt.dur;
              pre        <= '0;
              cnt        <= 8'd0;
            end
          end
          ST_PLAY, ST_GAP: begin
            if (to_gap) begin
              state      <= ST_GAP;
              note       <= NOTE_REST;
              note_valid <= 1'b0;
              pre        <= '0;
              cnt        <= 8'd0;
            end else if (entry_done && finish) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
              state      <= ST_PLAY;
              index      <= 8'd0;
              note       <= first.note;
              note_valid <= pitched(first);
              cur_dur    <= first.dur;
`else
              state      <= ST_DONE;
              done       <= 1'b1;
              note       <= NOTE_REST;
              note_valid <= 1'b0;
`endif
              pre        <= '0;
              cnt        <= 8'd0;
            end else if (entry_done) begin
              state      <= ST_PLAY;
              index      <= index + 8'd1;
              note       <= nxt.note;
              note_valid <= pitched(nxt);
              cur_dur    <= nxt.dur;
              pre        <= '0;
              cnt        <= 8'd0;
            end else if (tick) begin
              pre <= '0;
              cnt <= cnt + 8'd1;
            end else begin
              pre <= pre + 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            index <= 8'd0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer (two melody tables in parallel)
module tb_note_sequencer;

  localparam int TD  = 4;   // TICK_DIV for CLK_HZ 4000 / TICK_HZ 1000
  localparam int GAP = 1;

  typedef struct {
    int note;
    int nv;
    int busy;
    int done;
    int idx;   // -1: index not compared
  } exp_t;

  function automatic logic [255:0][11:0] mel_a();
    logic [255:0][11:0] m;
    m = '0;
    m[0] = {4'd0, 8'd2};
    m[1] = {4'd4, 8'd1};
    m[2] = {4'd7, 8'd0};
    return m;
  endfunction

  function automatic logic [255:0][11:0] mel_b();
    logic [255:0][11:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i] = {4'(i), 8'(i % 3 + 1)};
    return m;
  endfunction

  localparam logic [255:0][11:0] MEL_A = mel_a();
  localparam logic [255:0][11:0] MEL_B = mel_b();

  logic clk, reset, start, stop;
  logic [3:0] a_note, b_note;
  logic       a_nv, b_nv, a_busy, b_busy, a_done, b_done;
  logic [7:0] a_index, b_index;

  note_sequencer #(.CLK_HZ(4000), .TICK_HZ(1000), .GAP_TICKS(GAP), .MELODY_LEN(3), .MELODY(MEL_A)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .note(a_note),
    .note_valid(a_nv), .busy(a_busy), .done(a_done), .index(a_index));

  note_sequencer #(.CLK_HZ(4000), .TICK_HZ(1000), .GAP_TICKS(GAP), .MELODY_LEN(16), .MELODY(MEL_B)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .note(b_note),
    .note_valid(b_nv), .busy(b_busy), .done(b_done), .index(b_index));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rom_note [2][16];
  int rom_dur  [2][16];
  int rom_len  [2];
  exp_t qa[$];
  exp_t qb[$];
  exp_t tr[$];
  exp_t idle_e = '{note: 15, nv: 0, busy: 0, done: 0, idx: 0};

  function automatic void cmp(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, expv);
    end
  endfunction

  function automatic void add(input int n, input int v, input int b, input int d, input int ix);
    exp_t e;
    e.note = n; e.nv = v; e.busy = b; e.done = d; e.idx = ix;
    tr.push_back(e);
  endfunction

  // Cycle-by-cycle expected output after a start, derived from the table contents.
  function automatic void build(input int k, input int maxn);
    int i;
    tr.delete();
    i = 0;
    while (tr.size() < maxn) begin
      for (int c = 0; c < rom_dur[k][i] * TD; c++)
        add(rom_note[k][i], (rom_note[k][i] <= 9) ? 1 : 0, 1, 0, i);
      for (int c = 0; c < GAP * TD; c++) add(15, 0, 1, 0, i);
      if (i + 1 == rom_len[k] || rom_dur[k][i + 1] == 0) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
        i = 0;
`else
        add(15, 0, 1, 1, -1);
        add(15, 0, 0, 0, 0);
        break;
`endif
      end else begin
        i++;
      end
    end
  endfunction

  task automatic push_exp(input int n);
    for (int k = 0; k < 2; k++) begin
      build(k, (n < 800) ? n : 800);
      for (int i = 0; i < tr.size() && i < n; i++) begin
        if (k == 0) qa.push_back(tr[i]);
        else        qb.push_back(tr[i]);
      end
    end
  endtask

  function automatic void check_one(input int k, input logic [3:0] n, input logic v,
                                    input logic b, input logic d, input logic [7:0] ix);
    exp_t e;
    string p;
    p = (k == 0) ? "a" : "b";
    e = idle_e;
    if (k == 0 && qa.size() > 0) e = qa.pop_front();
    if (k == 1 && qb.size() > 0) e = qb.pop_front();
    cmp({p, ".note"}, int'(n), e.note);
    cmp({p, ".note_valid"}, int'(v), e.nv);
    cmp({p, ".busy"}, int'(b), e.busy);
    cmp({p, ".done"}, int'(d), e.done);
    if (e.idx >= 0) cmp({p, ".index"}, int'(ix), e.idx);
  endfunction

  always @(negedge clk) begin
    cyc++;
    check_one(0, a_note, a_nv, a_busy, a_done, a_index);
    check_one(1, b_note, b_nv, b_busy, b_done, b_index);
  end

  task automatic chk_reset();
    cmp("rst.a_note", int'(a_note), 15);
    cmp("rst.a_note_valid", int'(a_nv), 0);
    cmp("rst.a_busy", int'(a_busy), 0);
    cmp("rst.a_done", int'(a_done), 0);
    cmp("rst.a_index", int'(a_index), 0);
    cmp("rst.b_note", int'(b_note), 15);
    cmp("rst.b_busy", int'(b_busy), 0);
    cmp("rst.b_index", int'(b_index), 0);
  endtask

  // ns: stop on output cycle ns; es: extra start on cycle es; rs: async reset after cycle rs.
  task automatic episode(input int ns, input int es, input int rs);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    push_exp(ns > 0 ? ns : (rs > 0 ? rs : 100000));
    for (int j = 1; j <= 600; j++) begin
      start = (es == j);
      stop  = (ns == j);
      if (rs == j) begin
        #5 reset = 1'b1;
        start = 1'b0;
        #1 chk_reset();
        @(posedge clk); #7 reset = 1'b0;
        break;
      end
      if (ns == j) begin
        @(posedge clk); #2 stop = 1'b0;
        break;
      end
      if (j > es && qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk); #2;
    end
    start = 1'b0;
    stop  = 1'b0;
    for (int w = 0; w < 8; w++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk);
    end
    cmp("drain.pending", qa.size() + qb.size(), 0);
    qa.delete();
    qb.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [255:0][11:0] m;
    int typ, ns, es, rs;
    m = MEL_A;
    for (int i = 0; i < 16; i++) begin
      rom_note[0][i] = int'(m[i][11:8]);
      rom_dur[0][i]  = int'(m[i][7:0]);
    end
    m = MEL_B;
    for (int i = 0; i < 16; i++) begin
      rom_note[1][i] = int'(m[i][11:8]);
      rom_dur[1][i]  = int'(m[i][7:0]);
    end
    rom_len[0] = 3;
    rom_len[1] = 16;

    reset = 1'b0; start = 1'b0; stop = 1'b0;
    #1 reset = 1'b1;
    #2 chk_reset();
    repeat (2) @(posedge clk);
    #7 reset = 1'b0;
    repeat (2) @(posedge clk);

`ifdef NOTE_SEQUENCER_LOOP_EN
    episode(65, 0, 0);
    episode(3, 0, 0);
    episode(30, 5, 0);
    episode(0, 0, 10);
    episode(25, 0, 0);
`else
    episode(0, 0, 0);
    episode(3, 0, 0);
    episode(0, 5, 0);
    episode(0, 0, 10);
    episode(0, 0, 0);
`endif

    for (int r = 0; r < 10; r++) begin
      typ = $urandom_range(0, 2);
`ifdef NOTE_SEQUENCER_LOOP_EN
      if (typ == 0) typ = 1;
`endif
      case (typ)
        0: begin
          es = $urandom_range(1, 21);
          episode(0, es, 0);
        end
        1: begin
          ns = $urandom_range(1, 45);
          es = $urandom_range(0, (ns < 21) ? ns : 21);
          episode(ns, es, 0);
        end
        default: begin
          rs = $urandom_range(1, 45);
          es = $urandom_range(0, (rs - 1 < 21) ? rs - 1 : 21);
          episode(0, es, rs);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
